ultrasonido_filtro: RTL and testbench

ULTRASONIDO_FILTRO -- requirements
Module: ultrasonido_filtro

---
 rtl/ultrasonido_filtro.sv | 192 +++++++++++++++++++
 tb/tb_ultrasonido_filtro.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ultrasonido_filtro.sv
// Ultrasonic distance conditioner: edge-qualified sampling, range rejection,
// 4-sample moving average with zone classification and a sensor watchdog.
module ultrasonido_filtro #(
    parameter int unsigned MAX_DIST = 400,
    parameter int unsigned THR_NEAR = 20,
    parameter int unsigned THR_FAR  = 100,
    parameter int unsigned TIMEOUT  = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done_in,
    input  logic [31:0] distance_in,
    output logic [15:0] dist_avg,
    output logic        avg_valid,
    output logic [1:0]  zone,
    output logic        sensor_fault,
    output logic [7:0]  reject_cnt
);

    localparam int unsigned      WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [15:0]      MAX_W   = 16'(MAX_DIST);
    localparam logic [15:0]      NEAR_W  = 16'(THR_NEAR);
    localparam logic [15:0]      FAR_W   = 16'(THR_FAR);
    localparam logic [1:0]       ZONE_NEAR = 2'b00;
    localparam logic [1:0]       ZONE_MID  = 2'b01;
    localparam logic [1:0]       ZONE_FAR  = 2'b10;
    localparam logic [1:0]       ZONE_NONE = 2'b11;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [15:0] sat16(input logic [31:0] d);
        if (|d[31:16]) begin
            return 16'hFFFF;
        end else begin
            return d[15:0];
        end
    endfunction

    function automatic logic [1:0] classify(input logic [15:0] avg);
        if (avg < NEAR_W) begin
            return ZONE_NEAR;
        end else if (avg >= FAR_W) begin
            return ZONE_FAR;
        end else begin
            return ZONE_MID;
        end
    endfunction

    state_t          state_r, state_nx;
    logic            armed_r, done_prev_r, pend_r, emit_r;
    logic [15:0]     sample_r;
    logic [15:0]     ring_r [0:3];
    logic [1:0]      ptr_r, fill_cnt_r;
    logic [17:0]     sum_r, sum_nx_s;
    logic [WD_W-1:0] wd_r;
    logic            edge_s, accept_s, reject_s, expire_s, emit_s;
    logic [15:0]     sat_s;

    // armed_r masks a done_in level that is already high when reset releases
    assign edge_s   = armed_r & done_in & ~done_prev_r;
    assign sat_s    = sat16(distance_in);
    assign accept_s = edge_s & (sat_s <= MAX_W);
    assign reject_s = edge_s & ~accept_s;
    assign expire_s = ~accept_s & (wd_r == WD_LAST);
    assign sum_nx_s = sum_r + {2'b00, sample_r} - {2'b00, ring_r[ptr_r]};
    assign emit_s   = pend_r & ~expire_s & ((state_r == RUN) | (fill_cnt_r == 2'd3));

    // Edge detection and capture of the qualified sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_r     <= 1'b0;
            done_prev_r <= 1'b0;
            pend_r      <= 1'b0;
            sample_r    <= 16'd0;
        end else begin
            armed_r     <= 1'b1;
            done_prev_r <= done_in;
            pend_r      <= accept_s;
            sample_r    <= sat_s;
        end
    end

    // FILL/RUN state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state: the fourth accepted fill sample moves to RUN, timeout restarts fill
    always_comb begin
        state_nx = state_r;
        if (expire_s) begin
            state_nx = FILL;
        end else if (pend_r) begin
            case (state_r)
                FILL:    begin
                    if (fill_cnt_r == 2'd3) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = FILL;
                    end
                end
                RUN:     state_nx = RUN;
                default: state_nx = FILL;
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Ring buffer and running sum; cleared entries make fill use the same update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) ring_r[i] <= 16'd0;
            ptr_r      <= 2'd0;
            fill_cnt_r <= 2'd0;
            sum_r      <= 18'd0;
        end else if (expire_s) begin
            for (int i = 0; i < 4; i++) ring_r[i] <= 16'd0;
            ptr_r      <= 2'd0;
            fill_cnt_r <= 2'd0;
            sum_r      <= 18'd0;
        end else if (pend_r) begin
            ring_r[ptr_r] <= sample_r;
            ptr_r         <= ptr_r + 2'd1;
            sum_r         <= sum_nx_s;
            if (state_r == FILL) begin
                fill_cnt_r <= fill_cnt_r + 2'd1;
            end else begin
                fill_cnt_r <= fill_cnt_r;
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Watchdog and reject counter, both saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_r       <= '0;
            reject_cnt <= 8'd0;
        end else begin
            if (accept_s) begin
                wd_r <= '0;
            end else if (wd_r != WD_MAX) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= wd_r;
            end
            if (reject_s && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end else begin
                reject_cnt <= reject_cnt;
            end
        end
    end

    // Registered outputs: average, strobe, zone and fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            emit_r       <= 1'b0;
            avg_valid    <= 1'b0;
            dist_avg     <= 16'd0;
            zone         <= ZONE_NONE;
            sensor_fault <= 1'b0;
        end else begin
            emit_r    <= emit_s;
            avg_valid <= emit_r;
            if (emit_r) begin
                dist_avg <= sum_r[17:2];
                zone     <= classify(sum_r[17:2]);
            end else if (expire_s) begin
                zone <= ZONE_NONE;
            end else begin
                zone <= zone;
            end
            if (accept_s) begin
                sensor_fault <= 1'b0;
            end else if (expire_s) begin
                sensor_fault <= 1'b1;
            end else begin
                sensor_fault <= sensor_fault;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonido_filtro.sv
// Directed self-checking bench for ultrasonido_filtro (TIMEOUT shortened to 100).
module tb_ultrasonido_filtro;

    logic        clk;
    logic        reset;
    logic        done_in;
    logic [31:0] distance_in;
    logic [15:0] dist_avg;
    logic        avg_valid;
    logic [1:0]  zone;
    logic        sensor_fault;
    logic [7:0]  reject_cnt;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int snap;

    ultrasonido_filtro #(
        .MAX_DIST(400), .THR_NEAR(20), .THR_FAR(100), .TIMEOUT(100)
    ) dut (
        .clk(clk), .reset(reset), .done_in(done_in), .distance_in(distance_in),
        .dist_avg(dist_avg), .avg_valid(avg_valid), .zone(zone),
        .sensor_fault(sensor_fault), .reject_cnt(reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (avg_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [31:0] v);
        @(negedge clk);
        distance_in = v;
        done_in     = 1'b1;
        @(negedge clk);
        done_in     = 1'b0;
    endtask

    // One-cycle done pulse, then checks the strobe exactly two edges later
    task automatic sample_chk(input string tag, input logic [31:0] v, input logic exp_strobe,
                              input logic [15:0] exp_avg, input logic [1:0] exp_zone);
        pulse(v);
        @(negedge clk);
        chk({tag, "_lat1"}, {31'd0, avg_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_strobe"}, {31'd0, avg_valid}, {31'd0, exp_strobe});
        if (exp_strobe) begin
            chk({tag, "_avg"}, {16'd0, dist_avg}, {16'd0, exp_avg});
            chk({tag, "_zone"}, {30'd0, zone}, {30'd0, exp_zone});
        end
        @(negedge clk);
        chk({tag, "_one"}, {31'd0, avg_valid}, 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        done_in     = 1'b0;
        distance_in = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_avg",   {16'd0, dist_avg},     32'd0);
        chk("rst_valid", {31'd0, avg_valid},    32'd0);
        chk("rst_zone",  {30'd0, zone},         32'd3);
        chk("rst_fault", {31'd0, sensor_fault}, 32'd0);
        chk("rst_rej",   {24'd0, reject_cnt},   32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Fill: 10,20,30,40 -> 25 MID only on the fourth
        sample_chk("fill1", 32'd10, 1'b0, 16'd0,  2'd0);
        sample_chk("fill2", 32'd20, 1'b0, 16'd0,  2'd0);
        sample_chk("fill3", 32'd30, 1'b0, 16'd0,  2'd0);
        sample_chk("fill4", 32'd40, 1'b1, 16'd25, 2'd1);

        // Wrap: 190>>2, 270>>2, 340>>2, 400>>2
        sample_chk("wrap1", 32'd100, 1'b1, 16'd47,  2'd1);
        sample_chk("wrap2", 32'd100, 1'b1, 16'd67,  2'd1);
        sample_chk("wrap3", 32'd100, 1'b1, 16'd85,  2'd1);
        sample_chk("wrap4", 32'd100, 1'b1, 16'd100, 2'd2);

        // Rejection and MAX_DIST boundary
        sample_chk("rej500", 32'd500,        1'b0, 16'd0, 2'd0);
        sample_chk("rejsat", 32'h0001_0000,  1'b0, 16'd0, 2'd0);
        chk("rej_cnt2",  {24'd0, reject_cnt}, 32'd2);
        chk("rej_hold",  {16'd0, dist_avg},   32'd100);
        chk("rej_zone",  {30'd0, zone},       32'd2);
        sample_chk("max400", 32'd400, 1'b1, 16'd175, 2'd2);
        sample_chk("rej401", 32'd401, 1'b0, 16'd0,   2'd0);
        chk("rej_cnt3",  {24'd0, reject_cnt}, 32'd3);

        // Held level: 50 cycles high gives a single sample (615>>2)
        #1 snap = strobe_cnt;
        @(negedge clk);
        distance_in = 32'd15;
        done_in     = 1'b1;
        repeat (50) @(negedge clk);
        done_in     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("held_strobes", strobe_cnt - snap,       32'd1);
        chk("held_avg",     {16'd0, dist_avg},       32'd153);
        chk("held_nofault", {31'd0, sensor_fault},   32'd0);

        // Timeout, then refill: 5,15,25,35 -> 20 MID; then 3 -> 19 NEAR
        repeat (60) @(negedge clk);
        chk("to_fault", {31'd0, sensor_fault}, 32'd1);
        chk("to_zone",  {30'd0, zone},         32'd3);
        chk("to_hold",  {16'd0, dist_avg},     32'd153);
        sample_chk("to_s5", 32'd5, 1'b0, 16'd0, 2'd0);
        chk("to_clear", {31'd0, sensor_fault}, 32'd0);
        sample_chk("to_s15", 32'd15, 1'b0, 16'd0, 2'd0);
        sample_chk("to_s25", 32'd25, 1'b0, 16'd0, 2'd0);
        chk("to_zone_kept", {30'd0, zone}, 32'd3);
        sample_chk("to_s35", 32'd35, 1'b1, 16'd20, 2'd1);
        sample_chk("near3",  32'd3,  1'b1, 16'd19, 2'd0);

        // Reject counter saturation
        #1 snap = strobe_cnt;
        for (int i = 0; i < 256; i++) pulse(32'd1000);
        repeat (3) @(negedge clk);
        #1;
        chk("rej_sat",     {24'd0, reject_cnt}, 32'd255);
        chk("rej_nostrobe", strobe_cnt - snap,  32'd0);

        // Reset one cycle after the edge of a fourth fill sample
        repeat (3) pulse(32'd50);
        #1 snap = strobe_cnt;
        pulse(32'd50);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_avg",   {16'd0, dist_avg},     32'd0);
        chk("mid_valid", {31'd0, avg_valid},    32'd0);
        chk("mid_zone",  {30'd0, zone},         32'd3);
        chk("mid_fault", {31'd0, sensor_fault}, 32'd0);
        chk("mid_rej",   {24'd0, reject_cnt},   32'd0);
        distance_in = 32'd8;
        done_in     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        done_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_nostrobe", strobe_cnt - snap, 32'd0);
        sample_chk("post1", 32'd8, 1'b0, 16'd0, 2'd0);
        sample_chk("post2", 32'd8, 1'b0, 16'd0, 2'd0);
        sample_chk("post3", 32'd8, 1'b0, 16'd0, 2'd0);
        sample_chk("post4", 32'd8, 1'b1, 16'd8, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
